// File: rtl/gb_pkg.sv
// Loader FSM state encoding and the framing/acknowledge byte values shared by
// the cartridge loader and its FIFO.
package gb_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    SUM,
    DRAIN,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
endpackage

// File: rtl/cart_loader_fifo.sv
// Byte FIFO between the UART and SRAM sides; head visible the cycle after push.
// Pushes while full and pops while empty are ignored; flush empties it.
module cart_loader_fifo
  import gb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cart_loader.sv
// Loads UART frames (55, LEN_LO, LEN_HI, payload, sum) into cartridge SRAM; writes are held until wr_ready.
// FIFO overflow aborts the frame; CART_LOADER_ACK_EN adds an ACK/NAK byte on tx_data/tx_valid.
module cart_loader
  import gb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic        prog,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] wr_address,
  output logic [7:0]  wr_data,
  output logic        wr_store,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);
  state_t      state;
  logic [7:0]  len_lo;
  logic [7:0]  run_sum;
  logic [15:0] remain;
  logic [15:0] addr;
  logic        sync_seen;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;

  assign sync_seen  = prog && (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  assign fifo_push  = prog && (state == DATA) && rx_valid && !fifo_full;
  assign fifo_flush = !prog || (state == ERR);
  // Gated directly so an abort, error or reset can never leak one more write.
  assign wr_store   = prog && !reset && (state != ERR) && !fifo_empty;
  assign fifo_pop   = wr_store && wr_ready;
  assign wr_data    = wr_store ? fifo_head : 8'h00;
  assign wr_address = addr;

  cart_loader_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clockgb),
    .reset(reset),
    .flush(fifo_flush),
    .push (fifo_push),
    .din  (rx_data),
    .pop  (fifo_pop),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clockgb) begin
    if (reset || sync_seen) addr <= BASE_ADDR;
    else if (fifo_pop)      addr <= addr + 16'd1;
  end

  always_ff @(posedge clockgb) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      len_lo  <= '0;
      remain  <= '0;
      run_sum <= '0;
    end else if (!prog) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sync_seen) begin
          state   <= LEN_LO;
          done    <= 1'b0;
          error   <= 1'b0;
          run_sum <= '0;
          busy    <= 1'b1;
        end
        LEN_LO: if (rx_valid) begin
          len_lo <= rx_data;
          state  <= LEN_HI;
        end
        // remain counts bytes still expected minus one, so LEN=0 yields 65536.
        LEN_HI: if (rx_valid) begin
          remain <= {rx_data, len_lo} - 16'd1;
          state  <= DATA;
        end
        DATA: if (rx_valid) begin
          if (fifo_full) begin
            state <= ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            run_sum <= run_sum + rx_data;
            if (remain == 16'd0) state <= SUM;
            else                 remain <= remain - 16'd1;
          end
        end
        SUM: if (rx_valid) begin
          if (rx_data == run_sum) begin
            state <= DRAIN;
          end else begin
            state <= ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DRAIN: if (fifo_empty) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // DONE and ERR each last exactly one cycle, so their decode is the ack strobe.
`ifdef CART_LOADER_ACK_EN
  assign tx_valid = (state == DONE) || (state == ERR);
  assign tx_data  = (state == DONE) ? ACK_BYTE : ((state == ERR) ? NAK_BYTE : 8'h00);
`else
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
`endif
endmodule

// File: tb/tb_cart_loader.sv
// Randomized frame bench for cart_loader with a queue-based write scoreboard
// and directed frames pinning addresses, checksum, overflow, abort and reset.
module tb_cart_loader;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hFFFE;

  logic        clockgb = 1'b0;
  logic        reset, prog, rx_valid, wr_ready, wr_store, busy, done, error, tx_valid;
  logic [7:0]  rx_data, wr_data, tx_data;
  logic [15:0] wr_address;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         rdy_mode = 1;      // 0: never ready, 1: always ready, 2: random
  bit         mon_en = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] tx_last = 8'h00;
  wr_t        exp_q[$];          // writes the model still expects, in order
  wr_t        log_q[$];          // writes the DUT completed
  logic [7:0] pay_q[$];
  logic [7:0] pre_q[$];
  logic [7:0] cks_g;

  cart_loader #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clockgb(clockgb), .reset(reset), .prog(prog), .rx_data(rx_data),
    .rx_valid(rx_valid), .wr_address(wr_address), .wr_data(wr_data),
    .wr_store(wr_store), .wr_ready(wr_ready), .busy(busy), .done(done),
    .error(error), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clockgb = ~clockgb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clockgb); #1;
      case (rdy_mode)
        0:       wr_ready = 1'b0;
        1:       wr_ready = 1'b1;
        default: wr_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Scoreboard: any visible write must be the next expected payload byte at BASE+index.
  always @(negedge clockgb) begin
    if (mon_en && wr_store) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, wr_store}, 32'd0);
      end else begin
        check("wr_address", {16'd0, wr_address}, {16'd0, exp_q[0].a});
        check("wr_data", {24'd0, wr_data}, {24'd0, exp_q[0].d});
        if (wr_ready) begin
          log_q.push_back('{a: wr_address, d: wr_data});
          exp_q.delete(0);
        end
      end
    end
    if (mon_en && tx_valid) begin
      tx_cnt++;
      tx_last = tx_data;
    end
  end

  task automatic tick();
    @(posedge clockgb); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_ack(input int tx0, input bit good);
`ifdef CART_LOADER_ACK_EN
    check("ack_count", tx_cnt, tx0 + 1);
    check("ack_byte", {24'd0, tx_last}, good ? 32'h06 : 32'h15);
`else
    check("ack_count", tx_cnt, tx0);
`endif
  endtask

  // Sends pre_q garbage, then a frame of pay_q with checksum cks_g.
  task automatic run_frame(input int max_gap);
    logic [7:0] s;
    bit         good;
    int         t;
    int         tx0;
    s = 8'h00;
    foreach (pay_q[i]) s = s + pay_q[i];
    good = (s == cks_g);
    tx0  = tx_cnt;
    log_q.delete();
    foreach (pre_q[i]) send(pre_q[i]);
    send(8'h55);
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("error_cleared", {31'd0, error}, 32'd0);
    send(8'(pay_q.size()));
    send(8'(pay_q.size() >> 8));
    foreach (pay_q[i]) begin
      exp_q.push_back('{a: BASE + 16'(i), d: pay_q[i]});
      send(pay_q[i]);
      repeat ($urandom_range(max_gap)) tick();
    end
    send(cks_g);
    t = 0;
    while (!(done || error) && t < 200) begin
      tick();
      t++;
    end
    check("frame_end_in_time", {31'd0, t < 200}, 32'd1);
    check("done_end", {31'd0, done}, {31'd0, good});
    check("error_end", {31'd0, error}, {31'd0, !good});
    check("busy_end", {31'd0, busy}, 32'd0);
    if (good) begin
      check("all_written", exp_q.size(), 0);
      check("write_count", log_q.size(), pay_q.size());
    end
    exp_q.delete();
    tick();
    check_ack(tx0, good);
  endtask

  initial begin
    int         tx0;
    int         len;
    bit         rnd;
    logic [7:0] b;
    logic [7:0] s;

    reset = 1'b1; prog = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clockgb);
    #1;
    reset = 1'b0;
    check("rst_wr_address", {16'd0, wr_address}, {16'd0, BASE});
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_wr_store", {31'd0, wr_store}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    mon_en = 1'b1;

    // Good 3-byte frame; base FFFE wraps to 0000 on the third byte.
    rdy_mode = 1;
    pre_q.delete(); pay_q = '{8'h11, 8'h22, 8'h33}; cks_g = 8'h66;
    run_frame(0);
    check("good_nwrites", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("good_w0", {8'd0, log_q[0]}, 32'h00FFFE11);
      check("good_w1", {8'd0, log_q[1]}, 32'h00FFFF22);
      check("good_w2", {8'd0, log_q[2]}, 32'h00000033);
    end
    check("good_done_lit", {31'd0, done}, 32'd1);

    // Same frame with a wrong checksum.
    pay_q = '{8'h11, 8'h22, 8'h33}; cks_g = 8'h67;
    run_frame(0);
    check("bad_nwrites", log_q.size(), 3);
    check("bad_error_lit", {31'd0, error}, 32'd1);
    check("bad_done_lit", {31'd0, done}, 32'd0);

    // Leading noise ignored.
    pre_q = '{8'h00, 8'hAA}; pay_q = '{8'h7F}; cks_g = 8'h7F;
    run_frame(1);
    check("noise_nwrites", log_q.size(), 1);
    if (log_q.size() == 1) check("noise_w0", {8'd0, log_q[0]}, 32'h00FFFE7F);

    // Dropping prog while idle must leave the sticky flags alone.
    prog = 1'b0;
    repeat (3) tick();
    check("prog_keeps_done", {31'd0, done}, 32'd1);
    check("prog_keeps_error", {31'd0, error}, 32'd0);
    prog = 1'b1;
    tick();

    // Overflow: no SRAM acceptance, fifth payload byte hits a full FIFO.
    rdy_mode = 0; tick(); tick();
    log_q.delete(); tx0 = tx_cnt;
    send(8'h55); send(8'h08); send(8'h00);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back('{a: BASE + 16'(i), d: b});
      send(b);
    end
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    check("ovf_no_write", log_q.size(), 0);
    exp_q.delete();
    tick();
    check_ack(tx0, 1'b0);
    check("ovf_wr_store_after", {31'd0, wr_store}, 32'd0);

    // Abort by prog after the second payload byte of a 10-byte frame.
    rdy_mode = 1; tick(); tick();
    log_q.delete();
    send(8'h55); send(8'h0A); send(8'h00);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      exp_q.push_back('{a: BASE + 16'(i), d: b});
      send(b);
    end
    prog = 1'b0;
    exp_q.delete();
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wr_store", {31'd0, wr_store}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) prog = 1'b1;
      b = 8'($urandom_range(8'h54));
      send(b);
    end
    repeat (3) tick();
    check("abort_busy_later", {31'd0, busy}, 32'd0);
    check("abort_writes_bounded", {31'd0, log_q.size() <= 2}, 32'd1);

    // Reset mid-frame discards pending bytes.
    rdy_mode = 0; tick(); tick();
    log_q.delete();
    send(8'h55); send(8'h04); send(8'h00);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      exp_q.push_back('{a: BASE + 16'(i), d: b});
      send(b);
    end
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_store", {31'd0, wr_store}, 32'd0);
    check("midrst_wr_address", {16'd0, wr_address}, {16'd0, BASE});
    rdy_mode = 1;
    repeat (5) tick();
    check("midrst_no_write", log_q.size(), 0);

    // Random frames: short ones under random wr_ready, longer ones with wr_ready held high.
    for (int f = 0; f < 25; f++) begin
      rnd = ($urandom_range(1) == 1);
      len = rnd ? int'($urandom_range(DEPTH, 1)) : int'($urandom_range(12, 1));
      rdy_mode = rnd ? 2 : 1;
      pre_q.delete(); pay_q.delete();
      repeat ($urandom_range(2)) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h54;
        pre_q.push_back(b);
      end
      s = 8'h00;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        s = s + b;
        pay_q.push_back(b);
      end
      cks_g = ($urandom_range(3) == 0) ? 8'(s + 8'($urandom_range(255, 1))) : s;
      run_frame(3);
    end

    rdy_mode = 1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
